// File: rtl/instruction_fetch_if.sv
// Fetch-side bundle: program ROM port, decoded instruction output and redirect requests.
// The master is the fetch unit. The slave is the ROM/decoder environment.
interface instruction_fetch_if;
    logic [9:0]  romAddr;
    logic        romEn;
    logic [15:0] romData;
    logic [15:0] instr;
    logic        instrValid;
    logic [9:0]  instrPc;
    logic        stall;
    logic        jmpEnable;
    logic        branchEnable;
    logic [9:0]  jmpDir;
    logic [5:0]  branchDir;

    modport master (
        output romAddr, romEn, instr, instrValid, instrPc,
        input  romData, stall, jmpEnable, branchEnable, jmpDir, branchDir
    );

    modport slave (
        input  romAddr, romEn, instr, instrValid, instrPc,
        output romData, stall, jmpEnable, branchEnable, jmpDir, branchDir
    );
endinterface

// File: rtl/instruction_fetch.sv
// Instruction fetch unit for a 1024-word synchronous program ROM. A FILL cycle primes the ROM
// read pipeline after reset or a redirect. RUN then streams one word per cycle.
module instruction_fetch (
    input logic                 Clock,
    input logic                 Reset,
    instruction_fetch_if.master bus
);

    typedef enum logic [0:0] {StFill, StRun} state_e;

    state_e      state_q, state_d;
    logic [9:0]  addr_q, addr_d;
    logic [9:0]  pc_q, pc_d;
    logic [15:0] instr_q, instr_d;
    logic        valid_q, valid_d;
    logic        rom_en;

    logic        redirect;
    logic        advance;
    logic [9:0]  target;

    // Redirects only act on a valid instruction the decoder has actually accepted.
    assign redirect = valid_q & ~bus.stall & (bus.jmpEnable | bus.branchEnable);
    assign advance  = ~redirect & (~valid_q | ~bus.stall);
    assign target   = bus.jmpEnable ? bus.jmpDir
                                    : pc_q + {{4{bus.branchDir[5]}}, bus.branchDir};

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        valid_d = valid_q;
        rom_en  = 1'b0;

        unique case (state_q)
            StFill: begin
                rom_en  = 1'b1;
                addr_d  = addr_q + 10'd1;
                state_d = StRun;
            end
            StRun: begin
                if (redirect) begin
                    addr_d  = target;
                    instr_d = 16'h0000;
                    valid_d = 1'b0;
                    state_d = StFill;
                end else if (advance) begin
                    // romData holds the word read from addr_q - 1 on the previous edge.
                    rom_en  = 1'b1;
                    instr_d = bus.romData;
                    pc_d    = addr_q - 10'd1;
                    valid_d = 1'b1;
                    addr_d  = addr_q + 10'd1;
                end
            end
        endcase
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q <= StFill;
            addr_q  <= 10'd0;
            pc_q    <= 10'd0;
            instr_q <= 16'h0000;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            valid_q <= valid_d;
        end
    end

    assign bus.romEn      = rom_en & ~Reset;
    assign bus.romAddr    = addr_q;
    assign bus.instr      = instr_q;
    assign bus.instrValid = valid_q;
    assign bus.instrPc    = pc_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: directed scenarios plus random stall/redirect traffic, checked
// against an instruction-stream model (next address to present, edges until it appears).
module tb_instruction_fetch;

    logic Clock = 1'b0;
    logic Reset = 1'b1;

    instruction_fetch_if bus ();

    instruction_fetch dut (
        .Clock (Clock),
        .Reset (Reset),
        .bus   (bus)
    );

    always #5 Clock = ~Clock;

    logic [15:0] mem [1024];

    always @(posedge Clock) begin
        if (bus.romEn) bus.romData <= mem[bus.romAddr];
    end

    int n_total = 0;
    int n_bad   = 0;

    // Stream model: m_next is the next address to present, m_wait the edges before it shows.
    logic        m_valid;
    logic [15:0] m_instr;
    logic [9:0]  m_pc;
    logic [9:0]  m_next;
    int          m_wait;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_valid = 1'b0;
        m_instr = 16'h0000;
        m_pc    = 10'd0;
        m_next  = 10'd0;
        m_wait  = 2;
    endtask

    function automatic logic [9:0] model_target();
        int t;
        if (bus.jmpEnable) return bus.jmpDir;
        t = int'(m_pc) + int'($signed(bus.branchDir));
        return 10'((t + 1024) % 1024);
    endfunction

    // Inputs are set by the caller just after the previous edge.
    task automatic tick();
        bit redir;
        logic [9:0] exp_addr;
        #1;
        redir = m_valid && !bus.stall && (bus.jmpEnable || bus.branchEnable);
        check("romEn", bus.romEn, !redir && (!m_valid || !bus.stall));
        @(posedge Clock);
        if (redir) begin
            m_next  = model_target();
            m_valid = 1'b0;
            m_instr = 16'h0000;
            m_wait  = 2;
        end else if (m_valid && bus.stall) begin
            // held
        end else if (m_wait == 2) begin
            m_wait = 1;
        end else begin
            m_instr = mem[m_next];
            m_pc    = m_next;
            m_valid = 1'b1;
            m_next  = 10'((int'(m_next) + 1) % 1024);
        end
        #1;
        exp_addr = (m_wait == 2) ? m_next : 10'((int'(m_next) + 1) % 1024);
        check("instrValid", bus.instrValid, m_valid);
        check("instr", bus.instr, m_instr);
        check("romAddr", bus.romAddr, exp_addr);
        if (m_valid) check("instrPc", bus.instrPc, m_pc);
    endtask

    task automatic pulse_reset(input bit scramble);
        #2 Reset = 1'b1;
        #1;
        check("rst_valid", bus.instrValid, 0);
        check("rst_instr", bus.instr, 0);
        check("rst_pc", bus.instrPc, 0);
        check("rst_addr", bus.romAddr, 0);
        check("rst_romEn", bus.romEn, 0);
        if (scramble) for (int i = 0; i < 1024; i++) mem[i] = 16'($urandom);
        #1 Reset = 1'b0;
        model_reset();
    endtask

    task automatic run_to(input logic [9:0] p);
        int n = 0;
        while (!(m_valid && m_pc == p) && n < 3000) begin
            tick();
            n++;
        end
        check("reach_valid", bus.instrValid, 1);
        check("reach_pc", bus.instrPc, p);
    endtask

    // Single redirect request, then the two edges until the target is presented.
    task automatic redirect(input bit j, input bit b, input logic [9:0] jd, input logic [5:0] bd);
        bus.jmpEnable    = j;
        bus.branchEnable = b;
        bus.jmpDir       = jd;
        bus.branchDir    = bd;
        tick();
        bus.jmpEnable    = 1'b0;
        bus.branchEnable = 1'b0;
        check("redir_bubble", bus.instrValid, 0);
        tick();
        check("redir_fill", bus.instrValid, 0);
        tick();
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 16'h1000 + 16'(i);
        bus.stall        = 1'b0;
        bus.jmpEnable    = 1'b0;
        bus.branchEnable = 1'b0;
        bus.jmpDir       = 10'd0;
        bus.branchDir    = 6'd0;
        model_reset();

        // Held reset
        repeat (2) begin
            @(posedge Clock);
            #1;
            check("hold_valid", bus.instrValid, 0);
            check("hold_addr", bus.romAddr, 0);
            check("hold_romEn", bus.romEn, 0);
        end
        #2 Reset = 1'b0;

        // Cold start
        tick();
        check("cold_edge1_valid", bus.instrValid, 0);
        for (int k = 0; k < 3; k++) begin
            tick();
            check("cold_instr", bus.instr, 16'h1000 + 16'(k));
            check("cold_pc", bus.instrPc, k);
        end

        // Stall at pc 5
        run_to(10'd5);
        bus.stall = 1'b1;
        repeat (3) begin
            tick();
            check("stall_instr", bus.instr, 16'h1005);
            check("stall_pc", bus.instrPc, 5);
            check("stall_addr", bus.romAddr, 7);
            check("stall_romEn", bus.romEn, 0);
        end
        bus.stall = 1'b0;
        tick();
        check("unstall_instr", bus.instr, 16'h1006);

        // Jump at pc 3
        pulse_reset(1'b0);
        run_to(10'd3);
        bus.jmpEnable = 1'b1;
        bus.jmpDir    = 10'h200;
        tick();
        bus.jmpEnable = 1'b0;
        check("jmp_bubble", bus.instrValid, 0);
        check("jmp_addr", bus.romAddr, 10'h200);
        tick();
        check("jmp_fill", bus.instrValid, 0);
        tick();
        check("jmp_instr", bus.instr, 16'h1200);
        check("jmp_pc", bus.instrPc, 10'h200);

        // Branches wrapping down and up
        redirect(1'b1, 1'b0, 10'h010, 6'd0);
        redirect(1'b0, 1'b1, 10'd0, 6'b111110);
        check("br_back_pc", bus.instrPc, 10'h00E);
        check("br_back_instr", bus.instr, 16'h100E);
        redirect(1'b1, 1'b0, 10'h3FE, 6'd0);
        redirect(1'b0, 1'b1, 10'd0, 6'd5);
        check("br_fwd_pc", bus.instrPc, 10'h003);
        check("br_fwd_instr", bus.instr, 16'h1003);

        // Jump beats branch
        redirect(1'b1, 1'b1, 10'h123, 6'd1);
        check("prio_pc", bus.instrPc, 10'h123);

        // Jump request held off by stall
        bus.stall     = 1'b1;
        bus.jmpEnable = 1'b1;
        bus.jmpDir    = 10'h050;
        repeat (2) begin
            tick();
            check("stjmp_valid", bus.instrValid, 1);
            check("stjmp_pc", bus.instrPc, 10'h123);
        end
        bus.stall = 1'b0;
        tick();
        bus.jmpEnable = 1'b0;
        check("stjmp_addr", bus.romAddr, 10'h050);
        repeat (2) tick();
        check("stjmp_target", bus.instrPc, 10'h050);

        // Sequential wrap
        redirect(1'b1, 1'b0, 10'h3FD, 6'd0);
        repeat (3) tick();
        check("wrap_pc", bus.instrPc, 10'h000);
        check("wrap_instr", bus.instr, 16'h1000);

        // Reset while a redirect fill is pending
        bus.jmpEnable = 1'b1;
        bus.jmpDir    = 10'h300;
        tick();
        bus.jmpEnable = 1'b0;
        pulse_reset(1'b0);
        repeat (2) tick();
        check("refetch_pc", bus.instrPc, 0);
        check("refetch_instr", bus.instr, 16'h1000);

        // Random traffic over a scrambled ROM
        pulse_reset(1'b1);
        for (int n = 0; n < 3000; n++) begin
            bus.stall        = ($urandom_range(0, 99) < 30);
            bus.jmpEnable    = ($urandom_range(0, 99) < 8);
            bus.branchEnable = ($urandom_range(0, 99) < 8);
            bus.jmpDir       = 10'($urandom_range(0, 1023));
            bus.branchDir    = 6'($urandom_range(0, 63));
            if ($urandom_range(0, 299) == 0) pulse_reset(1'b0);
            tick();
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, bad=%0d", n_bad);
        $fatal(1);
    end

endmodule
